// File: rtl/mpu_sample_sequencer.sv
// Sequencer that sweeps the MPU-6050 register-read wrapper across selectors 0..13.
// It packs the captured bytes into seven signed 16-bit samples and publishes them atomically.
module mpu_sample_sequencer #(
  parameter int unsigned EN_CYCLES     = 5,
  parameter int unsigned SETTLE_CYCLES = 2500,
  parameter int unsigned SAMPLE_PERIOD = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_en,
  input  logic [7:0]  data,
  output logic [3:0]  register_selector,
  output logic        en,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] temp,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned CNT_MAX = (EN_CYCLES > SETTLE_CYCLES) ? EN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PER_W   = $clog2(SAMPLE_PERIOD + 1);
  localparam int unsigned NBYTES  = 14;

  localparam logic [CNT_W-1:0] EN_LAST     = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LAST    = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [3:0]       IDX_LAST    = 4'(NBYTES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_PULSE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state, state_next;
  logic [3:0]       idx, idx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [PER_W-1:0] pcnt;
  logic             period_tick;
  logic [7:0]       shadow [NBYTES];

  assign period_tick = auto_en && (pcnt == PER_LAST);

  // State, byte index and phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (start || period_tick) begin
          state_next = S_SELECT;
          idx_next   = '0;
        end
      end
      S_SELECT: begin
        state_next = S_PULSE;
        cnt_next   = '0;
      end
      S_PULSE: begin
        if (cnt == EN_LAST) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt == SETTLE_LAST) begin
          state_next = S_CAPTURE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        if (idx == IDX_LAST) begin
          state_next = S_DONE;
        end else begin
          state_next = S_SELECT;
          idx_next   = idx + 4'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Free-running period counter; held at zero while auto mode is off
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt    <= '0;
      overrun <= 1'b0;
    end else begin
      if (!auto_en || period_tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PER_W'(1);
      end
      if (period_tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  // Strobes track the next state so they are aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      en                <= 1'b0;
      busy              <= 1'b0;
      sample_valid      <= 1'b0;
      register_selector <= '0;
    end else begin
      en           <= (state_next == S_PULSE);
      busy         <= (state_next != S_IDLE);
      sample_valid <= (state_next == S_DONE);
      if (state_next == S_SELECT) begin
        register_selector <= idx_next;
      end
    end
  end

  // Shadow bytes and published sample; the last byte bypasses the shadow into the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        shadow[i] <= '0;
      end
      accel_x <= '0;
      accel_y <= '0;
      accel_z <= '0;
      temp    <= '0;
      gyro_x  <= '0;
      gyro_y  <= '0;
      gyro_z  <= '0;
    end else begin
      if (state == S_CAPTURE) begin
        shadow[idx] <= data;
      end
      if ((state == S_CAPTURE) && (state_next == S_DONE)) begin
        accel_x <= {shadow[0],  shadow[1]};
        accel_y <= {shadow[2],  shadow[3]};
        accel_z <= {shadow[4],  shadow[5]};
        temp    <= {shadow[6],  shadow[7]};
        gyro_x  <= {shadow[8],  shadow[9]};
        gyro_y  <= {shadow[10], shadow[11]};
        gyro_z  <= {shadow[12], data};
      end
    end
  end

endmodule

// File: tb/tb_mpu_sample_sequencer.sv
// Directed bench for mpu_sample_sequencer: sweep timing, packing, atomicity, auto mode, reset.
module tb_mpu_sample_sequencer;

  localparam int unsigned EN_CYC     = 5;
  localparam int unsigned SETTLE_CYC = 20;
  localparam int          T          = 27;
  localparam int          SWEEP_LAT  = 14 * T + 1;

  logic        clk = 1'b0;
  logic        rst, start, auto_en;
  logic [7:0]  base;
  logic [7:0]  data, data_f;
  logic [3:0]  register_selector, sel_f;
  logic        en, en_f;
  logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
  logic [15:0] accel_x_f, accel_y_f, accel_z_f, temp_f, gyro_x_f, gyro_y_f, gyro_z_f;
  logic        sample_valid, busy, overrun;
  logic        sample_valid_f, busy_f, overrun_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign data   = base + {4'h0, register_selector};
  assign data_f = base + {4'h0, sel_f};

  mpu_sample_sequencer #(.EN_CYCLES(EN_CYC), .SETTLE_CYCLES(SETTLE_CYC), .SAMPLE_PERIOD(500)) u_dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .data(data),
    .register_selector(register_selector), .en(en),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  mpu_sample_sequencer #(.EN_CYCLES(EN_CYC), .SETTLE_CYCLES(SETTLE_CYC), .SAMPLE_PERIOD(300)) u_dut_fast (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .data(data_f),
    .register_selector(sel_f), .en(en_f),
    .accel_x(accel_x_f), .accel_y(accel_y_f), .accel_z(accel_z_f), .temp(temp_f),
    .gyro_x(gyro_x_f), .gyro_y(gyro_y_f), .gyro_z(gyro_z_f),
    .sample_valid(sample_valid_f), .busy(busy_f), .overrun(overrun_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sample(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    // bytes 0..6 use base b0, bytes 7..13 use base b1
    check_eq({tag, "_accel_x"}, 32'(accel_x), 32'(16'h1011 + {b0, b0} - 16'h1010));
    check_eq({tag, "_accel_y"}, 32'(accel_y), 32'({b0 + 8'd2, b0 + 8'd3}));
    check_eq({tag, "_accel_z"}, 32'(accel_z), 32'({b0 + 8'd4, b0 + 8'd5}));
    check_eq({tag, "_temp"},    32'(temp),    32'({b0 + 8'd6, b1 + 8'd7}));
    check_eq({tag, "_gyro_x"},  32'(gyro_x),  32'({b1 + 8'd8, b1 + 8'd9}));
    check_eq({tag, "_gyro_y"},  32'(gyro_y),  32'({b1 + 8'd10, b1 + 8'd11}));
    check_eq({tag, "_gyro_z"},  32'(gyro_z),  32'({b1 + 8'd12, b1 + 8'd13}));
  endtask

  initial begin
    int lat, busy_cnt, pulses, bad_w, bad_gap, bad_sel, sel_chg, w, last_rise, early_chg, idle;
    int nv, badi, lastv, firstv, nv_f, badi_f, lastv_f, waited;
    logic prev_en;
    logic [3:0] prev_sel;
    logic [111:0] old_sample;

    rst = 1'b1; start = 1'b0; auto_en = 1'b0; base = 8'h10;
    repeat (3) step();
    check_eq("rst_en", 32'(en), 32'd0);
    check_eq("rst_sel", 32'(register_selector), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(sample_valid), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_accel_x", 32'(accel_x), 32'd0);
    check_eq("rst_gyro_z", 32'(gyro_z), 32'd0);
    rst = 1'b0;
    step();

    // Single sweep with strobe-timing monitor
    start = 1'b1; step(); start = 1'b0;
    busy_cnt = 0; pulses = 0; bad_w = 0; bad_gap = 0; bad_sel = 0; sel_chg = 0;
    w = 0; last_rise = 0; prev_en = 1'b0; prev_sel = register_selector;
    for (lat = 1; lat < 2000; lat++) begin
      if (busy) busy_cnt++;
      if (register_selector != prev_sel) sel_chg++;
      if (en && !prev_en) begin
        if (pulses > 0 && (lat - last_rise) != T) bad_gap++;
        if (32'(prev_sel) != 32'(pulses)) bad_sel++;
        if (32'(register_selector) != 32'(pulses)) bad_sel++;
        last_rise = lat; pulses++; w = 0;
      end
      if (en) w++;
      if (!en && prev_en && w != int'(EN_CYC)) bad_w++;
      if (sample_valid) break;
      prev_en = en; prev_sel = register_selector;
      step();
    end
    check_eq("sweep_latency", 32'(lat), 32'(SWEEP_LAT));
    check_eq("sweep_busy_cycles", 32'(busy_cnt), 32'(SWEEP_LAT));
    check_eq("sweep_pulses", 32'(pulses), 32'd14);
    check_eq("sweep_en_width_bad", 32'(bad_w), 32'd0);
    check_eq("sweep_en_gap_bad", 32'(bad_gap), 32'd0);
    check_eq("sweep_sel_bad", 32'(bad_sel), 32'd0);
    check_eq("sweep_sel_changes", 32'(sel_chg), 32'd13);
    check_sample("sweep", 8'h10, 8'h10);
    step();
    check_eq("sweep_valid_one_cycle", 32'(sample_valid), 32'd0);
    check_eq("sweep_busy_after", 32'(busy), 32'd0);
    step();

    // Atomicity: data model changes after byte 6 is captured
    old_sample = {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
    start = 1'b1; step(); start = 1'b0;
    early_chg = 0;
    for (lat = 1; lat < 2000; lat++) begin
      if (sample_valid) break;
      if ({accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z} != old_sample) early_chg++;
      if (lat == 200) base = 8'hA0;
      step();
    end
    check_eq("atomic_early_change", 32'(early_chg), 32'd0);
    check_eq("atomic_latency", 32'(lat), 32'(SWEEP_LAT));
    check_sample("atomic", 8'h10, 8'hA0);
    base = 8'h10;
    repeat (2) step();

    // start held high: back-to-back sweeps with one idle cycle
    start = 1'b1;
    waited = 0;
    while (!sample_valid && waited < 2000) begin step(); waited++; end
    check_eq("held_first_valid", 32'(sample_valid), 32'd1);
    step();
    idle = 0;
    while (!busy && idle < 10) begin idle++; step(); end
    check_eq("held_idle_cycles", 32'(idle), 32'd1);
    start = 1'b0;
    waited = 0;
    while (!sample_valid && waited < 2000) begin step(); waited++; end
    check_eq("held_second_valid", 32'(sample_valid), 32'd1);
    step();
    check_eq("held_busy_after", 32'(busy), 32'd0);
    step();

    // Auto mode on both period settings
    auto_en = 1'b1;
    nv = 0; badi = 0; lastv = 0; firstv = -1; nv_f = 0; badi_f = 0; lastv_f = 0;
    for (int i = 0; i < 2400; i++) begin
      step();
      if (i == 1999) auto_en = 1'b0;
      if (sample_valid) begin
        if (nv == 0) firstv = i;
        else if (i - lastv != 500) badi++;
        lastv = i; nv++;
      end
      if (sample_valid_f) begin
        if (nv_f > 0 && i - lastv_f != 600) badi_f++;
        lastv_f = i; nv_f++;
      end
    end
    check_eq("auto_count", 32'(nv), 32'd4);
    check_eq("auto_first", 32'(firstv), 32'(499 + SWEEP_LAT - 1));
    check_eq("auto_interval_bad", 32'(badi), 32'd0);
    check_eq("auto_overrun", 32'(overrun), 32'd0);
    check_eq("fast_count", 32'(nv_f), 32'd3);
    check_eq("fast_interval_bad", 32'(badi_f), 32'd0);
    check_eq("fast_overrun", 32'(overrun_f), 32'd1);
    check_eq("fast_accel_x", 32'(accel_x_f), 32'h1011);
    check_eq("fast_accel_y", 32'(accel_y_f), 32'h1213);
    check_eq("fast_accel_z", 32'(accel_z_f), 32'h1415);
    check_eq("fast_temp", 32'(temp_f), 32'h1617);
    check_eq("fast_gyro_x", 32'(gyro_x_f), 32'h1819);
    check_eq("fast_gyro_y", 32'(gyro_y_f), 32'h1A1B);
    check_eq("fast_gyro_z", 32'(gyro_z_f), 32'h1C1D);
    check_eq("fast_busy", 32'(busy_f), 32'd0);
    check_eq("fast_en", 32'(en_f), 32'd0);

    // Reset mid-sweep while byte 6 is being strobed
    start = 1'b1; step(); start = 1'b0;
    waited = 0;
    while (!(en && register_selector == 4'd6) && waited < 2000) begin step(); waited++; end
    check_eq("midrst_reached_idx6", 32'(en && register_selector == 4'd6), 32'd1);
    rst = 1'b1;
    step();
    check_eq("midrst_en", 32'(en), 32'd0);
    check_eq("midrst_sel", 32'(register_selector), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_valid", 32'(sample_valid), 32'd0);
    check_eq("midrst_accel_x", 32'(accel_x), 32'd0);
    check_eq("midrst_gyro_z", 32'(gyro_z), 32'd0);
    check_eq("midrst_overrun_fast", 32'(overrun_f), 32'd0);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (sample_valid) nv++;
    end
    check_eq("midrst_no_valid", 32'(nv), 32'd0);
    check_eq("midrst_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
